// File: rtl/wordle_score_ctrl_if.sv
// Request/colour-write bundle between the game FSM (master) and the scorer (slave).
interface wordle_score_ctrl_if;
    logic        start;
    logic [2:0]  row;
    logic [39:0] guess;
    logic [39:0] target;
    logic        busy;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic [2:0]  wr_color;
    logic        done;
    logic        win;
    logic        invalid;

    modport master (
        output start, row, guess, target,
        input  busy, wr_en, wr_row, wr_col, wr_color, done, win, invalid
    );

    modport slave (
        input  start, row, guess, target,
        output busy, wr_en, wr_row, wr_col, wr_color, done, win, invalid
    );
endinterface

// File: rtl/wordle_score_ctrl.sv
// Two-pass letter-count scorer for one Wordle guess; writes five tile colours to the display array.
// Optional macro WORDLE_INVALID_GUESS_EN: a non-letter guess character aborts scoring and flags invalid.
module wordle_score_ctrl #(
    parameter int       NUM_ROWS     = 6,
    parameter logic [2:0] COLOR_GREEN  = 3'b010,
    parameter logic [2:0] COLOR_YELLOW = 3'b110,
    parameter logic [2:0] COLOR_WHITE  = 3'b111
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    wordle_score_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] ROW_LIMIT = 4'(NUM_ROWS);

    state_t      state_r, state_nxt_s;
    logic [2:0]  i_r, i_nxt_s;
    logic [39:0] guess_r, guess_nxt_s;
    logic [39:0] target_r, target_nxt_s;
    logic [2:0]  row_r, row_nxt_s;
    logic [2:0]  cnt_r [26];
    logic [2:0]  cnt_nxt_s [26];
    logic [2:0]  tile_r [5];
    logic [2:0]  tile_nxt_s [5];
    logic        win_r, win_nxt_s;
    logic        busy_r, wr_en_r, done_r;
    logic [2:0]  wr_row_r, wr_col_r, wr_color_r;
    logic [7:0]  g_ch_s, t_ch_s;
    logic [4:0]  g_idx_s, t_idx_s;
    logic        all_green_s;
`ifdef WORDLE_INVALID_GUESS_EN
    logic        flag_r, flag_nxt_s;
    logic        invalid_r, invalid_nxt_s;
`endif

    function automatic logic [7:0] char_at(input logic [39:0] word, input logic [2:0] pos);
        logic [7:0] ch;
        case (pos)
            3'd0:    ch = word[39:32];
            3'd1:    ch = word[31:24];
            3'd2:    ch = word[23:16];
            3'd3:    ch = word[15:8];
            default: ch = word[7:0];
        endcase
        return ch;
    endfunction

    function automatic logic is_letter(input logic [7:0] ch);
        logic [7:0] folded;
        folded = ch | 8'h20;
        return (folded >= 8'h61) && (folded <= 8'h7a);
    endfunction

    function automatic logic [4:0] letter_idx(input logic [7:0] ch);
        return 5'((ch | 8'h20) - 8'h61);
    endfunction

    assign all_green_s = (tile_r[0] == COLOR_GREEN) && (tile_r[1] == COLOR_GREEN) &&
                         (tile_r[2] == COLOR_GREEN) && (tile_r[3] == COLOR_GREEN) &&
                         (tile_r[4] == COLOR_GREEN);

    // Next-state, scoring passes and capture logic
    always_comb begin
        state_nxt_s  = state_r;
        i_nxt_s      = i_r;
        guess_nxt_s  = guess_r;
        target_nxt_s = target_r;
        row_nxt_s    = row_r;
        win_nxt_s    = win_r;
        for (int k = 0; k < 26; k++) cnt_nxt_s[k] = cnt_r[k];
        for (int k = 0; k < 5; k++)  tile_nxt_s[k] = tile_r[k];
`ifdef WORDLE_INVALID_GUESS_EN
        flag_nxt_s    = flag_r;
        invalid_nxt_s = invalid_r;
`endif
        g_ch_s  = char_at(guess_r, i_r);
        t_ch_s  = char_at(target_r, i_r);
        g_idx_s = letter_idx(g_ch_s);
        t_idx_s = letter_idx(t_ch_s);

        case (state_r)
            ST_IDLE: begin
                if (bus.start && ({1'b0, bus.row} < ROW_LIMIT)) begin
                    guess_nxt_s  = bus.guess;
                    target_nxt_s = bus.target;
                    row_nxt_s    = bus.row;
                    win_nxt_s    = 1'b0;
                    for (int k = 0; k < 26; k++) cnt_nxt_s[k] = 3'd0;
                    for (int k = 0; k < 5; k++)  tile_nxt_s[k] = COLOR_WHITE;
`ifdef WORDLE_INVALID_GUESS_EN
                    flag_nxt_s    = 1'b0;
                    invalid_nxt_s = 1'b0;
`endif
                    state_nxt_s = ST_GREEN;
                    i_nxt_s     = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GREEN: begin
                // Unmatched target letters feed the counters that YELLOW later spends
                if (is_letter(g_ch_s) && ((g_ch_s | 8'h20) == (t_ch_s | 8'h20))) begin
                    tile_nxt_s[i_r] = COLOR_GREEN;
                end else if (is_letter(t_ch_s)) begin
                    cnt_nxt_s[t_idx_s] = cnt_r[t_idx_s] + 3'd1;
                end else begin
                    tile_nxt_s[i_r] = tile_r[i_r];
                end
`ifdef WORDLE_INVALID_GUESS_EN
                if (!is_letter(g_ch_s)) begin
                    flag_nxt_s = 1'b1;
                end else begin
                    flag_nxt_s = flag_r;
                end
`endif
                if (i_r == 3'd4) begin
                    i_nxt_s = 3'd0;
`ifdef WORDLE_INVALID_GUESS_EN
                    if (flag_nxt_s) begin
                        state_nxt_s   = ST_DONE;
                        invalid_nxt_s = 1'b1;
                        win_nxt_s     = 1'b0;
                    end else begin
                        state_nxt_s = ST_YELLOW;
                    end
`else
                    state_nxt_s = ST_YELLOW;
`endif
                end else begin
                    i_nxt_s = i_r + 3'd1;
                end
            end
            ST_YELLOW: begin
                if ((tile_r[i_r] != COLOR_GREEN) && is_letter(g_ch_s) && (cnt_r[g_idx_s] != 3'd0)) begin
                    tile_nxt_s[i_r]    = COLOR_YELLOW;
                    cnt_nxt_s[g_idx_s] = cnt_r[g_idx_s] - 3'd1;
                end else begin
                    tile_nxt_s[i_r] = tile_r[i_r];
                end
                if (i_r == 3'd4) begin
                    state_nxt_s = ST_WRITE;
                    i_nxt_s     = 3'd0;
                end else begin
                    i_nxt_s = i_r + 3'd1;
                end
            end
            ST_WRITE: begin
                if (i_r == 3'd4) begin
                    state_nxt_s = ST_DONE;
                    i_nxt_s     = 3'd0;
                    win_nxt_s   = all_green_s;
                end else begin
                    i_nxt_s = i_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                i_nxt_s     = 3'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                i_nxt_s     = 3'd0;
            end
        endcase
    end

    // State, working storage and registered outputs
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            i_r        <= 3'd0;
            guess_r    <= 40'd0;
            target_r   <= 40'd0;
            row_r      <= 3'd0;
            win_r      <= 1'b0;
            busy_r     <= 1'b0;
            wr_en_r    <= 1'b0;
            done_r     <= 1'b0;
            wr_row_r   <= 3'd0;
            wr_col_r   <= 3'd0;
            wr_color_r <= 3'd0;
            for (int k = 0; k < 26; k++) cnt_r[k] <= 3'd0;
            for (int k = 0; k < 5; k++)  tile_r[k] <= COLOR_WHITE;
`ifdef WORDLE_INVALID_GUESS_EN
            flag_r    <= 1'b0;
            invalid_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            i_r      <= i_nxt_s;
            guess_r  <= guess_nxt_s;
            target_r <= target_nxt_s;
            row_r    <= row_nxt_s;
            win_r    <= win_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_r   <= (state_nxt_s == ST_DONE);
            for (int k = 0; k < 26; k++) cnt_r[k] <= cnt_nxt_s[k];
            for (int k = 0; k < 5; k++)  tile_r[k] <= tile_nxt_s[k];
`ifdef WORDLE_INVALID_GUESS_EN
            flag_r    <= flag_nxt_s;
            invalid_r <= invalid_nxt_s;
`endif
            // Write port is loaded one cycle ahead so it is a clean register output
            if (state_nxt_s == ST_WRITE) begin
                wr_en_r    <= 1'b1;
                wr_row_r   <= row_nxt_s;
                wr_col_r   <= i_nxt_s;
                wr_color_r <= tile_nxt_s[i_nxt_s];
            end else begin
                wr_en_r    <= 1'b0;
                wr_row_r   <= 3'd0;
                wr_col_r   <= 3'd0;
                wr_color_r <= 3'd0;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_row   = wr_row_r;
    assign bus.wr_col   = wr_col_r;
    assign bus.wr_color = wr_color_r;
    assign bus.done     = done_r;
    assign bus.win      = win_r;
`ifdef WORDLE_INVALID_GUESS_EN
    assign bus.invalid  = invalid_r;
`else
    assign bus.invalid  = 1'b0;
`endif

endmodule

// File: tb/tb_wordle_score_ctrl.sv
// Directed-vector bench for wordle_score_ctrl: hand-scored guesses, cycle-exact write/done timing.
module tb_wordle_score_ctrl;

    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b110;
    localparam logic [2:0] W = 3'b111;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    wordle_score_ctrl_if bus ();

    wordle_score_ctrl dut (
        .Clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one start at edge 0 and observe cycles 1..18 (sampled 1ns after each edge).
    task automatic run_guess(
        input  logic [39:0] tgt,
        input  logic [39:0] gss,
        input  logic [2:0]  r,
        input  int          pulse_a,
        input  int          pulse_b,
        input  int          rst_at,
        output int          n_wr,
        output logic [14:0] cols,
        output int          n_done,
        output int          done_cyc,
        output logic        win_s,
        output logic        inv_s,
        output logic [18:0] busy_m,
        output int          seq_err
    );
        n_wr = 0; cols = 15'd0; n_done = 0; done_cyc = 0;
        win_s = 1'b0; inv_s = 1'b0; busy_m = 19'd0; seq_err = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.row = r; bus.guess = gss; bus.target = tgt;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.guess = ~gss; bus.target = ~tgt;
        for (int c = 1; c <= 18; c++) begin
            bus.start = (c == pulse_a || c == pulse_b) ? 1'b1 : 1'b0;
            if (rst_at != 0 && c == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_wr_en", {39'd0, bus.wr_en}, 40'd0);
                chk("rst_busy", {39'd0, bus.busy}, 40'd0);
            end
            if (rst_at != 0 && c == rst_at + 1) reset_n = 1'b1;
            busy_m[c] = bus.busy;
            if (bus.wr_en === 1'b1) begin
                n_wr++;
                if ((c - 11) != int'(bus.wr_col) || bus.wr_row !== r) seq_err++;
                if (bus.wr_col <= 3'd4) cols[3*bus.wr_col +: 3] = bus.wr_color;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = c;
                win_s = bus.win;
                inv_s = bus.invalid;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    int          n_wr, n_done, done_cyc, seq_err;
    logic [14:0] cols;
    logic        win_s, inv_s;
    logic [18:0] busy_m;

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.row = 3'd0; bus.guess = 40'd0; bus.target = 40'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {39'd0, bus.busy}, 40'd0);
        chk("reset_wr_en", {39'd0, bus.wr_en}, 40'd0);
        chk("reset_done", {39'd0, bus.done}, 40'd0);
        chk("reset_win", {39'd0, bus.win}, 40'd0);
        chk("reset_invalid", {39'd0, bus.invalid}, 40'd0);
        chk("reset_wr_bus", {31'd0, bus.wr_row, bus.wr_col, bus.wr_color}, 40'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Exact match: five greens, win
        run_guess("CRANE", "CRANE", 3'd0, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("crane_nwr", 40'(n_wr), 40'd5);
        chk("crane_cols", {25'd0, cols}, {25'd0, G, G, G, G, G});
        chk("crane_seq", 40'(seq_err), 40'd0);
        chk("crane_done_cyc", 40'(done_cyc), 40'd16);
        chk("crane_ndone", 40'(n_done), 40'd1);
        chk("crane_win", {39'd0, win_s}, 40'd1);
        chk("crane_inv", {39'd0, inv_s}, 40'd0);
        chk("crane_busy", {21'd0, busy_m}, 40'h1FFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("win_hold", {39'd0, bus.win}, 40'd1);

        // Anagram: four yellows and one green on row 2
        run_guess("CRANE", "NACRE", 3'd2, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("nacre_cols", {25'd0, cols}, {25'd0, G, Y, Y, Y, Y});
        chk("nacre_seq", 40'(seq_err), 40'd0);
        chk("nacre_win", {39'd0, win_s}, 40'd0);

        // Duplicate letters: one spare B goes to the leftmost unmatched B
        run_guess("ABBEY", "BOBBY", 3'd3, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("bobby_cols", {25'd0, cols}, {25'd0, G, W, G, W, Y});
        chk("bobby_win", {39'd0, win_s}, 40'd0);

        // Lower-case guess with stray starts at cycles 3 and 12
        run_guess("CRANE", "crane", 3'd5, 3, 12, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("busy_start_nwr", 40'(n_wr), 40'd5);
        chk("busy_start_ndone", 40'(n_done), 40'd1);
        chk("lower_cols", {25'd0, cols}, {25'd0, G, G, G, G, G});
        chk("lower_win", {39'd0, win_s}, 40'd1);
        chk("lower_seq", 40'(seq_err), 40'd0);

        // Row out of range is ignored; win from the previous score is kept
        run_guess("CRANE", "CRANE", 3'd6, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("row6_nwr", 40'(n_wr), 40'd0);
        chk("row6_ndone", 40'(n_done), 40'd0);
        chk("row6_busy", {21'd0, busy_m}, 40'd0);
        chk("row6_win_hold", {39'd0, bus.win}, 40'd1);

        // Reset in the middle of the write burst
        run_guess("CRANE", "NACRE", 3'd1, 0, 0, 13, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("midrst_nwr", 40'(n_wr), 40'd2);
        chk("midrst_ndone", 40'(n_done), 40'd0);
        chk("midrst_busy", {21'd0, busy_m}, 40'h1FFE);
        chk("midrst_win", {39'd0, bus.win}, 40'd0);

        // Non-letter in the guess
        run_guess("CRANE", "CR4NE", 3'd1, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
`ifdef WORDLE_INVALID_GUESS_EN
        chk("cr4ne_nwr", 40'(n_wr), 40'd0);
        chk("cr4ne_done_cyc", 40'(done_cyc), 40'd6);
        chk("cr4ne_inv", {39'd0, inv_s}, 40'd1);
        chk("cr4ne_win", {39'd0, win_s}, 40'd0);
        chk("cr4ne_busy", {21'd0, busy_m}, 40'h7E);
`else
        chk("cr4ne_nwr", 40'(n_wr), 40'd5);
        chk("cr4ne_cols", {25'd0, cols}, {25'd0, G, G, W, G, G});
        chk("cr4ne_done_cyc", 40'(done_cyc), 40'd16);
        chk("cr4ne_inv", {39'd0, inv_s}, 40'd0);
        chk("cr4ne_win", {39'd0, win_s}, 40'd0);
`endif

        // Normal scoring after reset / invalid; invalid must be clear
        run_guess("ABBEY", "ABBEY", 3'd4, 0, 0, 0, n_wr, cols, n_done, done_cyc, win_s, inv_s, busy_m, seq_err);
        chk("after_nwr", 40'(n_wr), 40'd5);
        chk("after_cols", {25'd0, cols}, {25'd0, G, G, G, G, G});
        chk("after_win", {39'd0, win_s}, 40'd1);
        chk("after_inv", {39'd0, inv_s}, 40'd0);
        chk("after_seq", 40'(seq_err), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
